// File: rtl/score_bcd_if.sv
// score_bcd_if: score/high-score channel between the score counter side and the
// BCD converter, grouping the binary input with the BCD display outputs.
interface score_bcd_if;
  logic        ending;
  logic [9:0]  score_in;
  logic [15:0] score_bcd;
  logic [15:0] best_bcd;
  logic [9:0]  best_bin;
  logic        score_upd;
  logic        best_upd;
  logic        busy;

  modport master (
    output ending,
    output score_in,
    input  score_bcd,
    input  best_bcd,
    input  best_bin,
    input  score_upd,
    input  best_upd,
    input  busy
  );

  modport slave (
    input  ending,
    input  score_in,
    output score_bcd,
    output best_bcd,
    output best_bin,
    output score_upd,
    output best_upd,
    output busy
  );
endinterface

// File: rtl/score_bcd_conv.sv
// score_bcd_conv: converts the running score and the session high score to 4-digit
// packed BCD with one shared bit-serial double-dabble engine; the high score wins ties.

module score_bcd_conv_chk (
  input logic        clk,
  input logic        rst,
  input logic [15:0] score_bcd,
  input logic [15:0] best_bcd,
  input logic        score_upd,
  input logic        best_upd
);
  function automatic logic bcd_ok(input logic [15:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) &&
           (v[11:8] <= 4'd9) && (v[15:12] <= 4'd1);
  endfunction

  a_score_digits: assert property (@(posedge clk) disable iff (!rst) bcd_ok(score_bcd));
  a_best_digits:  assert property (@(posedge clk) disable iff (!rst) bcd_ok(best_bcd));
  a_score_pulse:  assert property (@(posedge clk) disable iff (!rst) score_upd |=> !score_upd);
  a_best_pulse:   assert property (@(posedge clk) disable iff (!rst) best_upd |=> !best_upd);
  a_one_channel:  assert property (@(posedge clk) disable iff (!rst) !(score_upd && best_upd));
endmodule

module score_bcd_conv (
  input logic        clk,
  input logic        rst,
  score_bcd_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'd9;

  state_t      state_r;
  state_t      state_next_s;
  logic        ending_d_r;
  logic        best_pend_r;
  logic [9:0]  best_bin_r;
  logic [9:0]  score_last_r;
  logic        sel_best_r;
  logic [15:0] bcd_r;
  logic [9:0]  bin_r;
  logic [3:0]  cnt_r;
  logic [15:0] score_bcd_r;
  logic [15:0] best_bcd_r;
  logic        score_upd_r;
  logic        best_upd_r;
  logic        busy_r;

  logic        ending_rise_s;
  logic        best_win_s;
  logic        score_req_s;
  logic        take_best_s;
  logic        take_score_s;
  logic [11:0] bcd_adj_s;

  function automatic logic [3:0] add3(input logic [3:0] d);
    logic [3:0] r;
    if (d >= 4'd5) begin
      r = d + 4'd3;
    end else begin
      r = d;
    end
    return r;
  endfunction

  assign ending_rise_s = bus.ending & ~ending_d_r;
  assign best_win_s    = ending_rise_s & (bus.score_in > best_bin_r);
  assign score_req_s   = (bus.score_in != score_last_r);
  // The thousands digit never reaches 5 for a 10-bit operand, so it is shifted unadjusted.
  assign bcd_adj_s     = {add3(bcd_r[11:8]), add3(bcd_r[7:4]), add3(bcd_r[3:0])};

  // Next-state and request arbitration.
  always_comb begin
    state_next_s = state_r;
    take_best_s  = 1'b0;
    take_score_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (best_pend_r) begin
          take_best_s  = 1'b1;
          state_next_s = ST_SHIFT;
        end else if (score_req_s) begin
          take_score_s = 1'b1;
          state_next_s = ST_SHIFT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_r == LAST_BIT) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // High-score capture on the rising edge of ending; a new capture outranks the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ending_d_r  <= 1'b0;
      best_bin_r  <= 10'd0;
      best_pend_r <= 1'b0;
    end else begin
      ending_d_r <= bus.ending;
      if (best_win_s) begin
        best_bin_r  <= bus.score_in;
        best_pend_r <= 1'b1;
      end else if (take_best_s) begin
        best_pend_r <= 1'b0;
      end
    end
  end

  // Operand latch and double-dabble shift engine.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score_last_r <= 10'd0;
      sel_best_r   <= 1'b0;
      bcd_r        <= 16'd0;
      bin_r        <= 10'd0;
      cnt_r        <= 4'd0;
    end else if (take_best_s) begin
      bin_r      <= best_bin_r;
      bcd_r      <= 16'd0;
      cnt_r      <= 4'd0;
      sel_best_r <= 1'b1;
    end else if (take_score_s) begin
      bin_r        <= bus.score_in;
      score_last_r <= bus.score_in;
      bcd_r        <= 16'd0;
      cnt_r        <= 4'd0;
      sel_best_r   <= 1'b0;
    end else if (state_r == ST_SHIFT) begin
      bcd_r <= {bcd_r[14:12], bcd_adj_s, bin_r[9]};
      bin_r <= {bin_r[8:0], 1'b0};
      cnt_r <= cnt_r + 4'd1;
    end
  end

  // Registered outputs: result write-back, update pulses and busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score_bcd_r <= 16'd0;
      best_bcd_r  <= 16'd0;
      score_upd_r <= 1'b0;
      best_upd_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      score_upd_r <= 1'b0;
      best_upd_r  <= 1'b0;
      busy_r      <= (state_next_s != ST_IDLE);
      if (state_r == ST_DONE) begin
        if (sel_best_r) begin
          best_bcd_r <= bcd_r;
          best_upd_r <= 1'b1;
        end else begin
          score_bcd_r <= bcd_r;
          score_upd_r <= 1'b1;
        end
      end
    end
  end

  assign bus.score_bcd = score_bcd_r;
  assign bus.best_bcd  = best_bcd_r;
  assign bus.best_bin  = best_bin_r;
  assign bus.score_upd = score_upd_r;
  assign bus.best_upd  = best_upd_r;
  assign bus.busy      = busy_r;

  score_bcd_conv_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .score_bcd (score_bcd_r),
    .best_bcd  (best_bcd_r),
    .score_upd (score_upd_r),
    .best_upd  (best_upd_r)
  );
endmodule

// File: tb/tb_score_bcd_conv.sv
// tb_score_bcd_conv: directed scenarios for the score/high-score BCD converter with
// hand-computed BCD values and edge-exact timing checks.
module tb_score_bcd_conv;
  logic clk;
  logic rst;
  int   check_cnt;
  int   pass_cnt;

  score_bcd_if bus ();

  score_bcd_conv dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    logic bad;
    rst = 1'b0;
    bus.ending = 1'b0;
    bus.score_in = 10'd0;
    run_edges(3);
    check_cnt++;
    if ({bus.score_bcd, bus.best_bcd, bus.best_bin, bus.score_upd, bus.best_upd, bus.busy} !== 45'd0)
      $display("FAIL reset_outputs: got %h want 0",
               {bus.score_bcd, bus.best_bcd, bus.best_bin, bus.score_upd, bus.best_upd, bus.busy});
    else pass_cnt++;
    rst = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      run_edges(1);
      if (bus.busy !== 1'b0 || bus.score_upd !== 1'b0 || bus.best_upd !== 1'b0 ||
          bus.score_bcd !== 16'h0000 || bus.best_bcd !== 16'h0000 || bus.best_bin !== 10'd0)
        bad = 1'b1;
    end
    check_cnt++;
    if (bad !== 1'b0) $display("FAIL idle_zero_hold: got activity=%b want 0", bad);
    else pass_cnt++;
  endtask

  task automatic test_step;
    bus.score_in = 10'd7;
    run_edges(11);
    check_cnt++;
    if (bus.score_bcd !== 16'h0000 || bus.busy !== 1'b1)
      $display("FAIL step_e10: got bcd=%h busy=%b want 0000 1", bus.score_bcd, bus.busy);
    else pass_cnt++;
    run_edges(1);
    check_cnt++;
    if (bus.score_bcd !== 16'h0007 || bus.score_upd !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL step_e11: got bcd=%h upd=%b busy=%b want 0007 1 0",
               bus.score_bcd, bus.score_upd, bus.busy);
    else pass_cnt++;
    run_edges(1);
    check_cnt++;
    if (bus.score_upd !== 1'b0) $display("FAIL step_upd_width: got %b want 0", bus.score_upd);
    else pass_cnt++;
  endtask

  task automatic test_values;
    logic [9:0]  vals [3] = '{10'd999, 10'd1023, 10'd10};
    logic [15:0] exps [3] = '{16'h0999, 16'h1023, 16'h0010};
    for (int i = 0; i < 3; i++) begin
      bus.score_in = vals[i];
      run_edges(12);
      check_cnt++;
      if (bus.score_bcd !== exps[i] || bus.score_upd !== 1'b1)
        $display("FAIL value_%0d: got bcd=%h upd=%b want %h 1",
                 vals[i], bus.score_bcd, bus.score_upd, exps[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_best_capture;
    int seen;
    bus.score_in = 10'd345;
    run_edges(12);
    check_cnt++;
    if (bus.score_bcd !== 16'h0345) $display("FAIL score_345: got %h want 0345", bus.score_bcd);
    else pass_cnt++;
    bus.ending = 1'b1;
    run_edges(1);
    check_cnt++;
    if (bus.best_bin !== 10'd345) $display("FAIL best_bin_capture: got %0d want 345", bus.best_bin);
    else pass_cnt++;
    run_edges(11);
    check_cnt++;
    if (bus.best_bcd !== 16'h0000 || bus.best_upd !== 1'b0)
      $display("FAIL best_early: got bcd=%h upd=%b want 0000 0", bus.best_bcd, bus.best_upd);
    else pass_cnt++;
    run_edges(1);
    check_cnt++;
    if (bus.best_bcd !== 16'h0345 || bus.best_upd !== 1'b1)
      $display("FAIL best_345: got bcd=%h upd=%b want 0345 1", bus.best_bcd, bus.best_upd);
    else pass_cnt++;
    bus.ending = 1'b0;
    bus.score_in = 10'd200;
    run_edges(12);
    check_cnt++;
    if (bus.score_bcd !== 16'h0200) $display("FAIL score_200: got %h want 0200", bus.score_bcd);
    else pass_cnt++;
    bus.ending = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      run_edges(1);
      if (bus.best_upd === 1'b1) seen++;
    end
    check_cnt++;
    if (seen != 0 || bus.best_bin !== 10'd345 || bus.best_bcd !== 16'h0345)
      $display("FAIL best_lower_ignored: got pulses=%0d bin=%0d bcd=%h want 0 345 0345",
               seen, bus.best_bin, bus.best_bcd);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    bus.ending = 1'b0;
    run_edges(1);
    bus.score_in = 10'd500;
    run_edges(3);
    bus.ending = 1'b1;
    run_edges(1);
    check_cnt++;
    if (bus.best_bin !== 10'd500) $display("FAIL mid_capture_bin: got %0d want 500", bus.best_bin);
    else pass_cnt++;
    run_edges(8);
    check_cnt++;
    if (bus.score_bcd !== 16'h0500 || bus.score_upd !== 1'b1 ||
        bus.best_bcd !== 16'h0345 || bus.best_upd !== 1'b0)
      $display("FAIL score_first: got s=%h su=%b b=%h bu=%b want 0500 1 0345 0",
               bus.score_bcd, bus.score_upd, bus.best_bcd, bus.best_upd);
    else pass_cnt++;
    run_edges(11);
    check_cnt++;
    if (bus.best_bcd !== 16'h0345) $display("FAIL best_queued_early: got %h want 0345", bus.best_bcd);
    else pass_cnt++;
    run_edges(1);
    check_cnt++;
    if (bus.best_bcd !== 16'h0500 || bus.best_upd !== 1'b1)
      $display("FAIL best_500: got bcd=%h upd=%b want 0500 1", bus.best_bcd, bus.best_upd);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    bus.ending = 1'b0;
    bus.score_in = 10'd812;
    run_edges(6);
    check_cnt++;
    if (bus.busy !== 1'b1) $display("FAIL busy_mid_conv: got %b want 1", bus.busy);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    check_cnt++;
    if ({bus.score_bcd, bus.best_bcd, bus.best_bin, bus.score_upd, bus.best_upd, bus.busy} !== 45'd0)
      $display("FAIL async_reset: got %h want 0",
               {bus.score_bcd, bus.best_bcd, bus.best_bin, bus.score_upd, bus.best_upd, bus.busy});
    else pass_cnt++;
    run_edges(2);
    rst = 1'b1;
    run_edges(11);
    check_cnt++;
    if (bus.score_bcd !== 16'h0000) $display("FAIL post_reset_early: got %h want 0000", bus.score_bcd);
    else pass_cnt++;
    run_edges(1);
    check_cnt++;
    if (bus.score_bcd !== 16'h0812 || bus.score_upd !== 1'b1 || bus.best_bin !== 10'd0)
      $display("FAIL post_reset_812: got bcd=%h upd=%b bin=%0d want 0812 1 0",
               bus.score_bcd, bus.score_upd, bus.best_bin);
    else pass_cnt++;
  endtask

  initial begin
    check_cnt = 0;
    pass_cnt  = 0;
    test_reset();
    test_step();
    test_values();
    test_best_capture();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule

// File: doc/score_bcd_conv.md
# score_bcd_conv

Consumes the 10-bit binary `score_out` from the score counter and drives the score display with 4-digit packed BCD for the current score and the session high score. It keeps the high score in binary and compares it against the final score at the rising edge of `ending`. A single sequential double-dabble engine (one bit per clock) serves both values. It sits between the score counter and the 7-segment/VGA text renderer.

## Interface
- No parameters. Widths are fixed: 10-bit binary in, 4 BCD digits out.
- `clk` in 1: system clock, the same clock as the score counter.
- `rst` in 1: asynchronous, active-low reset. Clears all state immediately.
- `ending` in 1: game-over level, the same signal fed to the score counter.
- `score_in` in 10: binary score, driven from the score counter `score_out`.
- `score_bcd` out 16: BCD of the last converted score, {thousands, hundreds, tens, ones}.
- `best_bcd` out 16: BCD of the high score.
- `best_bin` out 10: binary high score.
- `score_upd` out 1: one-cycle pulse when `score_bcd` changes.
- `best_upd` out 1: one-cycle pulse when `best_bcd` changes.
- `busy` out 1: high while the converter is outside IDLE.

## Operation
- All outputs reset to 0. Internal state also resets to 0: `score_last`, `best_pend`, `ending_d`, the shift register, and the bit counter. FSM resets to IDLE.
- High-score capture:
  - `ending_d` registers `ending`.
  - A rising edge is `ending & ~ending_d`.
  - On a rising edge where `score_in > best_bin`: load `best_bin <= score_in` and set `best_pend`.
  - When the comparison fails, nothing changes.
  - The score counter zeroes its output one cycle after `ending` rises, so `score_in` still holds the final score on that edge.
- Score request: pending whenever `score_in != score_last`.
- FSM states:
  - IDLE: if `best_pend`, latch `best_bin` as the operand, clear `best_pend`, select the BEST channel, and go to SHIFT. Otherwise, if a score request is pending, latch `score_in` as the operand, copy it to `score_last`, select the SCORE channel, and go to SHIFT. BEST has priority over SCORE.
  - SHIFT: 10 cycles. Each cycle adds 3 to every BCD nibble that is ≥5, then shifts {bcd[15:0], bin[9:0]} left by 1. The bit counter runs 0 to 9; on count 9 go to DONE.
  - DONE: write the 16-bit BCD to the selected output, pulse the matching `*_upd` for the following cycle, then return to IDLE.
- Value range: the thousands nibble can only be 0 or 1 (maximum input 1023 gives 0x1023). No saturation is needed, and no BCD digit ever exceeds 9.
- `score_in` changing during a conversion does not disturb it. The latched operand completes, then IDLE sees the mismatch and starts a new conversion with the newest value. Intermediate values may be skipped.
- An `ending` rise during a conversion sets `best_pend`. The BEST conversion runs right after the current one.
- The `ending` level has no effect other than its rising edge. `best_bin` persists across games and is cleared only by `rst`.
- Reset asserted mid-conversion aborts it. Outputs return to 0 asynchronously. After reset is released, a nonzero `score_in` triggers a fresh conversion.

## Timing
- Let E0 be the edge at which IDLE accepts a request.
- SHIFT occupies edges E1 through E10. The DONE action takes effect at E11.
- The new BCD value is visible after E11. `*_upd` is high for exactly the cycle between E11 and E12.
- Back-to-back conversions: the next E0 is E12, giving a throughput of one conversion per 12 cycles.
- `busy` is high from after E0 until after E11.
- Capture timing: `best_bin` updates at edge X, where X is the edge that samples the `ending` rise. If idle, the BEST conversion E0 is edge X+1. `best_upd` is high between edges X+12 and X+13.
- Worst-case conversion latency is 23 cycles (a SCORE conversion in flight plus a queued BEST). Score updates occur every 20e6 cycles, so nothing is lost at game rate.

## Test plan
- Reset, then hold `score_in`=0 for 50 cycles. Required: all outputs 0, `busy` never asserts, no upd pulses.
- Step `score_in` 0→7. Required: `score_bcd`=0x0007 exactly 12 edges after the change is sampled (E0 through E11, visible after E11), and `score_upd` high for 1 cycle.
- Apply `score_in`=999, then 1023, then 10. Required: `score_bcd` = 0x0999, then 0x1023, then 0x0010.
- Hold `score_in`=345 and raise `ending`. Required: `best_bin`=345, `best_bcd`=0x0345, one `best_upd` pulse. Then lower `ending`, apply 200, and raise `ending` again. Required: `best_bin` stays 345 and no `best_upd`.
- Raise `ending` (score 500 > best) at E3 of a SCORE conversion. Required: the SCORE result is written first, and `best_bcd`=0x0500 twelve edges after that DONE.
- Assert `rst` at E5 of a conversion of 812. Required: all outputs are 0 immediately. After release, `score_bcd`=0x0812 within 12 edges.
